// File: rtl/video_palette_out.sv
// Palette output stage: video plex index -> CRAM lookup -> registered RGB
// with delay-matched sync/blank, plus a CPU write / handshaked read port.
module video_palette_out #(
    parameter int CRAM_AW = 8,
    parameter int COLOR_W = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_stb,
    input  logic               hpix_stb,
    input  logic               hires,
    input  logic [3:0]         hires_pal,
    input  logic [7:0]         vplex_in,
    input  logic               blank_in,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               cram_we,
    input  logic [CRAM_AW-1:0] cram_addr,
    input  logic [COLOR_W-1:0] cram_wdata,
    input  logic               cram_re,
    output logic               cram_rbusy,
    output logic               cram_rvalid,
    output logic [COLOR_W-1:0] cram_rdata,
    output logic [COLOR_W-1:0] rgb_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_out
);

    typedef enum logic [1:0] {
        R_IDLE,
        R_PEND,
        R_ISSUE
    } rd_st_e;

    logic [COLOR_W-1:0] mem_q [2**CRAM_AW];

    rd_st_e             st_q;
    logic [CRAM_AW-1:0] caddr_q;
    logic               rbusy_q;
    logic               rvalid_q;
    logic [COLOR_W-1:0] rdata_q;

    logic [CRAM_AW-1:0] idx_q, idx_d;
    logic [3:0]         lo_nib_q;
    logic               vid_rd_q;
    logic               vid_s2_q;
    logic               blk_s0_q, hs_s0_q, vs_s0_q;
    logic               blk_s1_q, hs_s1_q, vs_s1_q;
    logic [COLOR_W-1:0] ram_q;

    logic [COLOR_W-1:0] rgb_q;
    logic               hso_q, vso_q, bo_q;

    logic               cap_lo, cap_hi, cap;
    logic               rd_cpu, rd_en;
    logic [CRAM_AW-1:0] rd_addr;
    logic [COLOR_W-1:0] rd_data;

    // pix_stb always wins; the second hi-res half only counts in hi-res
    assign cap_lo = pix_stb;
    assign cap_hi = hpix_stb & hires & ~pix_stb;
    assign cap    = cap_lo | cap_hi;

    always_comb begin
        idx_d = idx_q;
        if (cap_lo) begin
            if (hires) begin
                idx_d = CRAM_AW'({hires_pal, vplex_in[7:4]});
            end else begin
                idx_d = CRAM_AW'(vplex_in);
            end
        end else if (cap_hi) begin
            idx_d = CRAM_AW'({hires_pal, lo_nib_q});
        end
    end

    // Video owns the read port whenever it needs it
    assign rd_cpu  = ~vid_rd_q & (st_q == R_PEND);
    assign rd_en   = vid_rd_q | rd_cpu;
    assign rd_addr = vid_rd_q ? idx_q : caddr_q;

    always_comb begin
        rd_data = mem_q[rd_addr];
        if (cram_we && (cram_addr == rd_addr)) begin
            rd_data = cram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (cram_we) begin
            mem_q[cram_addr] <= cram_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            lo_nib_q <= '0;
            vid_rd_q <= 1'b0;
            vid_s2_q <= 1'b0;
            blk_s0_q <= 1'b0;
            hs_s0_q  <= 1'b0;
            vs_s0_q  <= 1'b0;
            blk_s1_q <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            ram_q    <= '0;
            rgb_q    <= '0;
            hso_q    <= 1'b0;
            vso_q    <= 1'b0;
            bo_q     <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            vid_rd_q <= cap;
            vid_s2_q <= vid_rd_q;
            if (cap_lo) begin
                lo_nib_q <= vplex_in[3:0];
                blk_s0_q <= blank_in;
                hs_s0_q  <= hsync_in;
                vs_s0_q  <= vsync_in;
            end
            if (rd_en) begin
                ram_q <= rd_data;
            end
            if (vid_rd_q) begin
                blk_s1_q <= blk_s0_q;
                hs_s1_q  <= hs_s0_q;
                vs_s1_q  <= vs_s0_q;
            end
            if (vid_s2_q) begin
                rgb_q <= blk_s1_q ? '0 : ram_q;
                hso_q <= hs_s1_q;
                vso_q <= vs_s1_q;
                bo_q  <= blk_s1_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= R_IDLE;
            caddr_q  <= '0;
            rbusy_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            unique case (st_q)
                R_IDLE: begin
                    if (cram_re) begin
                        st_q    <= R_PEND;
                        caddr_q <= cram_addr;
                        rbusy_q <= 1'b1;
                    end
                end
                R_PEND: begin
                    if (!vid_rd_q) begin
                        st_q <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    st_q     <= R_IDLE;
                    rbusy_q  <= 1'b0;
                    rvalid_q <= 1'b1;
                    rdata_q  <= ram_q;
                end
                default: begin
                    st_q    <= R_IDLE;
                    rbusy_q <= 1'b0;
                end
            endcase
        end
    end

    assign cram_rbusy  = rbusy_q;
    assign cram_rvalid = rvalid_q;
    assign cram_rdata  = rdata_q;
    assign rgb_out     = rgb_q;
    assign hsync_out   = hso_q;
    assign vsync_out   = vso_q;
    assign blank_out   = bo_q;

endmodule

// File: tb/tb_video_palette_out.sv
// Scoreboard bench for video_palette_out: directed pixel and CPU vectors,
// monitor checks video 2 clk after each strobe and CPU data on rvalid.
module tb_video_palette_out;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_stb, hpix_stb, hires;
    logic [3:0]  hires_pal;
    logic [7:0]  vplex_in;
    logic        blank_in, hsync_in, vsync_in;
    logic        cram_we;
    logic [7:0]  cram_addr;
    logic [14:0] cram_wdata;
    logic        cram_re;
    logic        cram_rbusy, cram_rvalid;
    logic [14:0] cram_rdata, rgb_out;
    logic        hsync_out, vsync_out, blank_out;

    typedef struct {
        logic [14:0] d;
        int          c;
    } cpu_exp_t;

    logic [17:0] vq[$];
    cpu_exp_t    cq[$];
    logic [17:0] last_exp = '0;
    logic [2:0]  sh = '0;
    logic        mon_en = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    video_palette_out #(.CRAM_AW(8), .COLOR_W(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_stb(pix_stb), .hpix_stb(hpix_stb),
        .hires(hires), .hires_pal(hires_pal),
        .vplex_in(vplex_in), .blank_in(blank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .cram_we(cram_we), .cram_addr(cram_addr),
        .cram_wdata(cram_wdata), .cram_re(cram_re),
        .cram_rbusy(cram_rbusy), .cram_rvalid(cram_rvalid),
        .cram_rdata(cram_rdata), .rgb_out(rgb_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_out(blank_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [14:0] d);
        cram_we = 1'b1; cram_addr = a; cram_wdata = d;
        tick();
        cram_we = 1'b0;
    endtask

    task automatic vid(input logic p, input logic h, input logic [7:0] v,
                       input logic b, input logic hs, input logic vs,
                       input logic [14:0] rgb);
        pix_stb = p; hpix_stb = h; vplex_in = v;
        blank_in = b; hsync_in = hs; vsync_in = vs;
        vq.push_back({rgb, hs, vs, b});
        tick();
        pix_stb = 1'b0; hpix_stb = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [17:0] act;
            act = {rgb_out, hsync_out, vsync_out, blank_out};
            if (sh[2]) begin
                if (vq.size() == 0) begin
                    chk("vid_extra", 32'd1, 32'd0);
                end else begin
                    last_exp = vq.pop_front();
                    chk("vid_out", {14'd0, act}, {14'd0, last_exp});
                end
            end
            if (sh[1]) chk("vid_hold", {14'd0, act}, {14'd0, last_exp});
            sh = {sh[1:0], pix_stb | (hpix_stb & hires)};
            if (cram_rvalid) begin
                if (cq.size() == 0) begin
                    chk("rvalid_extra", 32'd1, 32'd0);
                end else begin
                    cpu_exp_t e;
                    e = cq.pop_front();
                    chk("rdata", {17'd0, cram_rdata}, {17'd0, e.d});
                    chk("rvalid_cyc", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            {pix_stb, hpix_stb, hires, blank_in, hsync_in, vsync_in} = 6'($urandom);
            {cram_we, cram_re} = 2'($urandom);
            hires_pal = 4'($urandom); vplex_in = 8'($urandom);
            cram_addr = 8'($urandom); cram_wdata = 15'($urandom);
            tick();
            chk("rst_rgb", {17'd0, rgb_out}, 32'd0);
            chk("rst_misc", {27'd0, hsync_out, vsync_out, blank_out,
                cram_rbusy, cram_rvalid}, 32'd0);
        end
        chk("rst_rdata", {17'd0, cram_rdata}, 32'd0);
        pix_stb = 0; hpix_stb = 0; hires = 0; hires_pal = 0;
        vplex_in = 0; blank_in = 0; hsync_in = 0; vsync_in = 0;
        cram_we = 0; cram_re = 0; cram_addr = 0; cram_wdata = 0;
        tick();
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (3) tick();
        chk("idle_out", {14'd0, rgb_out, hsync_out, vsync_out, blank_out},
            32'd0);
        chk("idle_busy", {31'd0, cram_rbusy}, 32'd0);

        wr(8'h5A, 15'h7C1F);
        vid(1, 0, 8'h5A, 0, 1, 0, 15'h7C1F);
        vid(1, 0, 8'h5A, 0, 0, 1, 15'h7C1F);

        wr(8'h77, 15'h7FFF);
        vid(1, 0, 8'h77, 1, 1, 1, 15'h0000);
        vid(1, 0, 8'h77, 0, 0, 0, 15'h7FFF);

        hires = 1'b1; hires_pal = 4'h3;
        wr(8'h31, 15'h001F);
        wr(8'h3E, 15'h03E0);
        wr(8'h33, 15'h1111);
        vid(1, 0, 8'h1E, 0, 0, 1, 15'h001F);
        vid(0, 1, 8'h00, 0, 0, 1, 15'h03E0);
        vid(1, 1, 8'h3E, 0, 1, 0, 15'h1111);
        vid(0, 1, 8'h00, 0, 1, 0, 15'h03E0);
        hires = 1'b0;
        hpix_stb = 1'b1;
        tick();
        hpix_stb = 1'b0;
        tick();
        vid(1, 0, 8'h31, 0, 0, 0, 15'h001F);

        wr(8'h10, 15'h2AAA);
        cram_re = 1'b1; cram_addr = 8'h10;
        cq.push_back('{d: 15'h2AAA, c: cyc + 3});
        tick();
        cram_re = 1'b0;
        chk("busy_free", {31'd0, cram_rbusy}, 32'd1);
        repeat (4) tick();

        cram_re = 1'b1; cram_addr = 8'h40;
        cq.push_back('{d: 15'h0BAD, c: cyc + 3});
        tick();
        cram_re = 1'b0;
        cram_we = 1'b1; cram_wdata = 15'h0BAD;
        tick();
        cram_we = 1'b0;
        repeat (4) tick();

        cram_re = 1'b1; cram_addr = 8'h10;
        pix_stb = 1'b1; vplex_in = 8'h5A;
        blank_in = 0; hsync_in = 0; vsync_in = 0;
        vq.push_back({15'h7C1F, 3'b000});
        cq.push_back('{d: 15'h2AAA, c: cyc + 4});
        tick();
        pix_stb = 1'b0;
        chk("busy_cont", {31'd0, cram_rbusy}, 32'd1);
        tick();
        cram_re = 1'b0;
        chk("busy_hold", {31'd0, cram_rbusy}, 32'd1);
        repeat (5) tick();
        chk("busy_done", {31'd0, cram_rbusy}, 32'd0);

        wr(8'h22, 15'h0F0F);
        pix_stb = 1'b1; vplex_in = 8'h22;
        vq.push_back({15'h1234, 3'b000});
        tick();
        pix_stb = 1'b0;
        cram_we = 1'b1; cram_addr = 8'h22; cram_wdata = 15'h1234;
        tick();
        cram_we = 1'b0;
        repeat (6) tick();

        chk("vq_empty", vq.size(), 32'd0);
        chk("cq_empty", cq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
